// File: rtl/mac_west_feeder.sv
// West-edge driver for a mac_tile row: queues 4-bit words in a small FIFO and, on start,
// issues one kernel-load word followed by num_act execute words on inst_w/out_w.
module mac_west_feeder #(
  parameter int unsigned bw     = 4,
  parameter int unsigned depth  = 8,
  parameter int unsigned cnt_bw = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [bw-1:0]     in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              start,
  input  logic [cnt_bw-1:0] num_act,
  output logic [bw-1:0]     out_w,
  output logic [1:0]        inst_w,
  output logic              busy,
  output logic              done,
  output logic              stall
);

  localparam int unsigned AW = $clog2(depth);

  localparam logic [1:0] InstIdle = 2'b00;
  localparam logic [1:0] InstLoad = 2'b01;
  localparam logic [1:0] InstExec = 2'b10;

  typedef enum logic [1:0] {StIdle, StLoad, StExec, StDone} state_e;

  // FIFO storage and wrap-bit pointers
  logic [bw-1:0] mem_q [depth];
  logic [AW:0]   wr_ptr_q, wr_ptr_d;
  logic [AW:0]   rd_ptr_q, rd_ptr_d;
  logic          full, empty, push, pop;
  logic [bw-1:0] head;

  // Sequencer state and registered outputs
  state_e            state_q, state_d;
  logic              pend_q, pend_d;
  logic [cnt_bw-1:0] cnt_q, cnt_d;
  logic [bw-1:0]     out_w_q, out_w_d;
  logic [1:0]        inst_w_q, inst_w_d;
  logic              stall_q, stall_d;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign in_ready = !full;
  // Full is taken from registered state, so a same-cycle pop never frees a slot early.
  assign push     = in_valid && !full;
  assign head     = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= in_data;
  end

  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    cnt_d    = cnt_q;
    out_w_d  = out_w_q;
    inst_w_d = InstIdle;
    stall_d  = 1'b0;
    pop      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!pend_q) begin
          if (start) begin
            pend_d = 1'b1;
            cnt_d  = num_act;
          end
        end else if (!empty) begin
          pop      = 1'b1;
          out_w_d  = head;
          inst_w_d = InstLoad;
          pend_d   = 1'b0;
          state_d  = StLoad;
        end
      end
      StLoad, StExec: begin
        if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          state_d = StExec;
          if (!empty) begin
            pop      = 1'b1;
            out_w_d  = head;
            inst_w_d = InstExec;
            cnt_d    = cnt_q - cnt_bw'(1);
          end else begin
            // Nothing to issue: hold out_w so the tile never sees a spurious word change.
            stall_d = 1'b1;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      state_q  <= StIdle;
      pend_q   <= 1'b0;
      cnt_q    <= '0;
      out_w_q  <= '0;
      inst_w_q <= InstIdle;
      stall_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      state_q  <= state_d;
      pend_q   <= pend_d;
      cnt_q    <= cnt_d;
      out_w_q  <= out_w_d;
      inst_w_q <= inst_w_d;
      stall_q  <= stall_d;
    end
  end

  assign out_w  = out_w_q;
  assign inst_w = inst_w_q;
  assign stall  = stall_q;
  assign busy   = (state_q == StLoad) || (state_q == StExec);
  assign done   = (state_q == StDone);

endmodule

// File: tb/tb_mac_west_feeder.sv
// Directed bench for mac_west_feeder: hand-computed inst_w/out_w sequences, FIFO full
// backpressure, stalls, ignored starts and asynchronous reset.
module tb_mac_west_feeder;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       start;
  logic [3:0] num_act;
  logic [3:0] out_w;
  logic [1:0] inst_w;
  logic       busy;
  logic       done;
  logic       stall;

  int errors = 0;
  int checks = 0;

  logic [3:0] t1 [7] = '{4'hF, 4'h1, 4'hC, 4'hD, 4'h9, 4'hF, 4'h1};

  mac_west_feeder #(
    .bw    (4),
    .depth (8),
    .cnt_bw(4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .start   (start),
    .num_act (num_act),
    .out_w   (out_w),
    .inst_w  (inst_w),
    .busy    (busy),
    .done    (done),
    .stall   (stall)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic st(input string tag, input logic [1:0] i, input logic [3:0] w,
                    input logic b, input logic d, input logic s);
    chk({tag, ".inst"}, {6'd0, inst_w}, {6'd0, i});
    chk({tag, ".out"}, {4'd0, out_w}, {4'd0, w});
    chk({tag, ".busy"}, {7'd0, busy}, {7'd0, b});
    chk({tag, ".done"}, {7'd0, done}, {7'd0, d});
    chk({tag, ".stall"}, {7'd0, stall}, {7'd0, s});
  endtask

  task automatic push_word(input logic [3:0] w);
    in_valid = 1'b1;
    in_data  = w;
    cyc();
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset    = 1'b0;
    in_data  = '0;
    in_valid = 1'b0;
    start    = 1'b0;
    num_act  = '0;
    #12;
    st("rst", 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("rst.in_ready", {7'd0, in_ready}, 8'd1);
    @(negedge clk);
    reset = 1'b1;
    cyc();

    // Full sequence F,1,C,D,9,F,1 with num_act=6
    for (int i = 0; i < 7; i++) push_word(t1[i]);
    num_act = 4'd6;
    start   = 1'b1;
    cyc();
    start = 1'b0;
    st("t1.pend", 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
    cyc();
    st("t1.load", 2'b01, 4'hF, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 7; i++) begin
      cyc();
      st($sformatf("t1.exec%0d", i), 2'b10, t1[i], 1'b1, 1'b0, 1'b0);
    end
    cyc();
    st("t1.done", 2'b00, 4'h1, 1'b0, 1'b1, 1'b0);
    cyc();
    st("t1.idle", 2'b00, 4'h1, 1'b0, 1'b0, 1'b0);

    // Stall: only 3 and 5 queued, 7 and 2 arrive late
    push_word(4'h3);
    push_word(4'h5);
    num_act = 4'd3;
    start   = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    st("t3.load", 2'b01, 4'h3, 1'b1, 1'b0, 1'b0);
    cyc();
    st("t3.exec5", 2'b10, 4'h5, 1'b1, 1'b0, 1'b0);
    cyc();
    st("t3.stall1", 2'b00, 4'h5, 1'b1, 1'b0, 1'b1);
    in_valid = 1'b1;
    in_data  = 4'h7;
    cyc();
    st("t3.stall2", 2'b00, 4'h5, 1'b1, 1'b0, 1'b1);
    in_data = 4'h2;
    cyc();
    in_valid = 1'b0;
    st("t3.exec7", 2'b10, 4'h7, 1'b1, 1'b0, 1'b0);
    cyc();
    st("t3.exec2", 2'b10, 4'h2, 1'b1, 1'b0, 1'b0);
    cyc();
    st("t3.done", 2'b00, 4'h2, 1'b0, 1'b1, 1'b0);
    cyc();

    // Backpressure: nine words 1..9 into depth 8, drained by num_act=8
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 4'(i + 1);
      cyc();
    end
    chk("t4.full", {7'd0, in_ready}, 8'd0);
    in_data = 4'h9;
    cyc();
    chk("t4.held", {7'd0, in_ready}, 8'd0);
    num_act = 4'd8;
    start   = 1'b1;
    cyc();
    start = 1'b0;
    chk("t4.pend_full", {7'd0, in_ready}, 8'd0);
    cyc();
    st("t4.load", 2'b01, 4'h1, 1'b1, 1'b0, 1'b0);
    chk("t4.after_pop", {7'd0, in_ready}, 8'd1);
    cyc();
    in_valid = 1'b0;
    st("t4.exec2", 2'b10, 4'h2, 1'b1, 1'b0, 1'b0);
    chk("t4.ready", {7'd0, in_ready}, 8'd1);
    for (int i = 3; i < 10; i++) begin
      cyc();
      st($sformatf("t4.exec%0d", i), 2'b10, 4'(i), 1'b1, 1'b0, 1'b0);
    end
    cyc();
    st("t4.done", 2'b00, 4'h9, 1'b0, 1'b1, 1'b0);
    cyc();

    // Start on empty FIFO, then E,4; second start during busy is ignored
    num_act = 4'd1;
    start   = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    st("t5.wait", 2'b00, 4'h9, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = 4'hE;
    cyc();
    in_data = 4'h4;
    st("t5.nobypass", 2'b00, 4'h9, 1'b0, 1'b0, 1'b0);
    cyc();
    in_valid = 1'b0;
    num_act  = 4'd5;
    start    = 1'b1;
    st("t5.load", 2'b01, 4'hE, 1'b1, 1'b0, 1'b0);
    cyc();
    start = 1'b0;
    st("t5.exec4", 2'b10, 4'h4, 1'b1, 1'b0, 1'b0);
    cyc();
    st("t5.done", 2'b00, 4'h4, 1'b0, 1'b1, 1'b0);
    cyc();
    push_word(4'hA);
    cyc();
    st("t5.ignored", 2'b00, 4'h4, 1'b0, 1'b0, 1'b0);

    // num_act=0 with A queued (left over from above)
    num_act = 4'd0;
    start   = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    st("t2.load", 2'b01, 4'hA, 1'b1, 1'b0, 1'b0);
    cyc();
    st("t2.done", 2'b00, 4'hA, 1'b0, 1'b1, 1'b0);
    cyc();
    st("t2.idle", 2'b00, 4'hA, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-EXEC, leftover words must be discarded
    for (int i = 6; i < 10; i++) push_word(4'(i));
    num_act = 4'd3;
    start   = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    st("t6.exec7", 2'b10, 4'h7, 1'b1, 1'b0, 1'b0);
    #3;
    reset = 1'b0;
    #1;
    st("t6.async", 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("t6.in_ready", {7'd0, in_ready}, 8'd1);
    @(negedge clk);
    reset = 1'b1;
    cyc();
    push_word(4'hB);
    push_word(4'hC);
    num_act = 4'd1;
    start   = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    st("t6.load", 2'b01, 4'hB, 1'b1, 1'b0, 1'b0);
    cyc();
    st("t6.execC", 2'b10, 4'hC, 1'b1, 1'b0, 1'b0);
    cyc();
    st("t6.done", 2'b00, 4'hC, 1'b0, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mac_west_feeder.md
# mac_west_feeder

West-edge driver for a `mac_tile` row. It buffers incoming 4-bit words in a small FIFO and, on a start command, emits the `inst_w`/`in_w` sequence the tile consumes: one kernel-load word (inst `2'b01`), then `num_act` execute words (inst `2'b10`), then idle (`2'b00`). It is the transmitting end of the tile's west input and replaces hand-written bench stimulus in array-level integration.

## Interface
- `bw`, 4, data word width; matches the tile's `bw`.
- `depth`, 8, FIFO entries; power of two, at least 2.
- `cnt_bw`, 4, width of the execute-count field.

- `clk`  input  1  sole clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low reset; `reset=0` clears all state immediately.
- `in_data`  input  bw  upstream word; the first word after start is the kernel, the rest are activations.
- `in_valid`  input  1  `in_data` is valid.
- `in_ready`  output  1  FIFO can accept a word; equals `!full`.
- `start`  input  1  one-cycle request to begin a load+execute sequence.
- `num_act`  input  cnt_bw  number of execute words; sampled when `start` is accepted.
- `out_w`  output  bw  to the tile's `in_w`; registered.
- `inst_w`  output  2  to the tile's `inst_w`: `00` idle, `01` kernel load, `10` execute; registered.
- `busy`  output  1  high from the load word through the last execute word.
- `done`  output  1  one-cycle pulse after the last execute word.
- `stall`  output  1  high in EXEC cycles where the FIFO is empty and no word is issued.

## Operation
- FIFO
  - A push occurs when `in_valid && in_ready`.
  - A pop occurs only when the feeder issues a word.
  - Pointers are `log2(depth)+1` bits wide and wrap; an occupancy counter of equal width is acceptable.
  - Full/empty are computed from registered state. A push at full is refused even if a pop happens in the same cycle.
  - There is no bypass: a word pushed at edge t is first poppable at edge t+1.
  - A simultaneous push and pop at mid-occupancy leaves occupancy unchanged.
- States: IDLE, LOAD, EXEC, DONE.
- IDLE
  - `inst_w=00`.
  - `start=1` latches `pend=1` and `cnt=num_act`.
  - `start` while `pend=1` or in any non-IDLE state is ignored.
  - With `pend=1` and FIFO non-empty, the FIFO pops on the edge. That same edge loads `out_w=head`, `inst_w=01`, clears `pend`, and moves to LOAD.
- LOAD lasts exactly one cycle. On the next edge:
  - If `cnt==0`, go to DONE.
  - Otherwise, if the FIFO is non-empty: pop, drive `out_w=head`, `inst_w=10`, decrement `cnt`, go to EXEC.
  - Otherwise, drive `inst_w=00`, hold `out_w`, and go to EXEC with `stall=1`.
- EXEC, on each edge:
  - If `cnt==0`: drive `inst_w=00` and go to DONE.
  - Otherwise, if the FIFO is non-empty: pop, drive `out_w=head`, `inst_w=10`, `stall=0`, and decrement `cnt`.
  - Otherwise: drive `inst_w=00`, hold `out_w`, `stall=1`.
- DONE lasts one cycle with `done=1` and `inst_w=00`, then goes to IDLE.
- `busy=1` in LOAD and EXEC only.
- `cnt` is `cnt_bw` bits and never underflows; the maximum sequence is `2^cnt_bw-1` execute words.
- Words left in the FIFO after DONE stay queued for the next start.

## Timing
- Reset values: `out_w=0`, `inst_w=00`, `in_ready=1` (FIFO empty), `busy=0`, `done=0`, `stall=0`, state IDLE, `pend=0`, `cnt=0`.
- Reset asserted mid-sequence aborts it asynchronously. All outputs take their reset values without waiting for a clock, and FIFO contents are discarded.
- Start latency with the FIFO non-empty:
  - `start` high at edge t → `inst_w=01` after edge t+1.
  - First `10` word after edge t+2.
- With no stalls, N execute words occupy edges t+2 … t+N+1. `done=1` follows edge t+N+2, and `busy` falls on that same edge.
- `in_ready` reflects occupancy after the previous edge: after `depth` pushes with no pops it is low in the next cycle.
- `out_w` changes only on an issue edge, so the tile sees a stable word for each inst cycle.

## Test plan
- Push F,1,C,D,9,F,1; `num_act=6`; pulse `start` → `inst_w`/`out_w` sequence is 01/F, 10/1, 10/C, 10/D, 10/9, 10/F, 10/1, then 00. `done` is one cycle, `busy` lasts 7 cycles, and the FIFO ends empty.
- `num_act=0` with A queued → a single 01/A, then `done` on the next cycle. No `10` words are issued.
- Push only kernel 3 and activation 5, `num_act=3`, start, then push 7 and 2 after 4 cycles → 01/3, 10/5, then `stall=1` with `inst_w=00` and `out_w` held at 5, then 10/7, 10/2, then `done`.
- Push 9 words into a depth-8 FIFO with `in_valid` held → `in_ready` low after 8 accepted pushes. The 9th word is held upstream and is accepted on the cycle after the first pop.
- `start` with the FIFO empty, then push E,4 with `num_act=1` → the sequence begins one edge after E becomes visible: 01/E, 10/4. A second `start` during `busy` is ignored.
- Drive `reset=0` mid-EXEC between clock edges → `inst_w=00`, `busy=0`, and `in_ready=1` immediately. After `reset=1`, a fresh sequence runs normally.
